// File: rtl/elevator_input_conditioner.sv
// Input conditioning for the 3-floor elevator controller. Raw pins are synchronised and
// debounced, then turned into press pulses, an encoded floor position and a sticky sensor fault.
module elevator_input_conditioner #(
  parameter int DEB_W       = 16,
  parameter int DEB_CYCLES  = 50000,
  parameter int CONF_W      = 16,
  parameter int CONF_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p1_raw,
  input  logic       p2_raw,
  input  logic       p3_raw,
  input  logic       f1_raw,
  input  logic       f2_raw,
  input  logic       f3_raw,
  input  logic       s_raw,
  output logic       p1,
  output logic       p2,
  output logic       p3,
  output logic       f1,
  output logic       f2,
  output logic       f3,
  output logic       s,
  output logic       p1_pulse,
  output logic       p2_pulse,
  output logic       p3_pulse,
  output logic [1:0] f_code,
  output logic       f_valid,
  output logic       sensor_fault
);

  localparam int N = 7;
  localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [CONF_W-1:0] CONF_MAX = CONF_W'(CONF_CYCLES);

  // Channel order: bits 2:0 buttons, 5:3 floor sensors, 6 stop.
  logic [N-1:0] raw;
  logic [N-1:0] sync1_reg;
  logic [N-1:0] sync2_reg;
  logic [N-1:0] level;

  assign raw = {s_raw, f3_raw, f2_raw, f1_raw, p3_raw, p2_raw, p1_raw};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_deb
      logic [DEB_W-1:0] cnt_reg;
      logic             level_reg;

      // Any sample matching the current level restarts the stability window.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_reg   <= '0;
          level_reg <= 1'b0;
        end else if (sync2_reg[gi] == level_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == DEB_LAST) begin
          level_reg <= sync2_reg[gi];
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + DEB_W'(1);
        end
      end

      assign level[gi] = level_reg;
    end
  endgenerate

  assign {s, f3, f2, f1, p3, p2, p1} = level;

  logic [2:0] press_d_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) press_d_reg <= '0;
    else       press_d_reg <= level[2:0];
  end

  assign {p3_pulse, p2_pulse, p1_pulse} = level[2:0] & ~press_d_reg;

  logic [2:0] floors;
  logic       conflict;

  assign floors   = level[5:3];
  assign conflict = (floors[0] & floors[1]) | (floors[0] & floors[2]) | (floors[1] & floors[2]);

  always_comb begin
    f_code  = 2'b00;
    f_valid = 1'b0;
    case (floors)
      3'b001: begin f_code = 2'b01; f_valid = 1'b1; end
      3'b010: begin f_code = 2'b10; f_valid = 1'b1; end
      3'b100: begin f_code = 2'b11; f_valid = 1'b1; end
      default: ;
    endcase
  end

  logic [CONF_W-1:0] conf_cnt_reg;
  logic              fault_reg;

  // Fault latches on the edge where the conflict count reaches CONF_CYCLES.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conf_cnt_reg <= '0;
      fault_reg    <= 1'b0;
    end else if (conflict) begin
      if (conf_cnt_reg != CONF_MAX) conf_cnt_reg <= conf_cnt_reg + CONF_W'(1);
      if (conf_cnt_reg >= CONF_MAX - CONF_W'(1)) fault_reg <= 1'b1;
    end else begin
      conf_cnt_reg <= '0;
    end
  end

  assign sensor_fault = fault_reg;

endmodule

// File: tb/tb_elevator_input_conditioner.sv
// Directed bench for elevator_input_conditioner with DEB_CYCLES=4, CONF_CYCLES=8.
// Inputs change and outputs are sampled 1 time unit after a rising edge.
module tb_elevator_input_conditioner;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic p1_raw = 0, p2_raw = 0, p3_raw = 0, f1_raw = 0, f2_raw = 0, f3_raw = 0, s_raw = 0;
  logic p1, p2, p3, f1, f2, f3, s, p1_pulse, p2_pulse, p3_pulse, f_valid, sensor_fault;
  logic [1:0] f_code;
  logic [6:0] lv;
  logic [2:0] pulses;

  int checks = 0;
  int fails  = 0;

  assign lv     = {s, f3, f2, f1, p3, p2, p1};
  assign pulses = {p3_pulse, p2_pulse, p1_pulse};

  elevator_input_conditioner #(
    .DEB_W(16), .DEB_CYCLES(4), .CONF_W(16), .CONF_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset),
    .p1_raw(p1_raw), .p2_raw(p2_raw), .p3_raw(p3_raw),
    .f1_raw(f1_raw), .f2_raw(f2_raw), .f3_raw(f3_raw), .s_raw(s_raw),
    .p1(p1), .p2(p2), .p3(p3), .f1(f1), .f2(f2), .f3(f3), .s(s),
    .p1_pulse(p1_pulse), .p2_pulse(p2_pulse), .p3_pulse(p3_pulse),
    .f_code(f_code), .f_valid(f_valid), .sensor_fault(sensor_fault)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_raw(input logic v);
    {p1_raw, p2_raw, p3_raw, f1_raw, f2_raw, f3_raw, s_raw} = {7{v}};
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    set_raw(1'b1);
    reset = 1'b1;
    tick(3);
    checks++;
    if ({lv, pulses, f_code, f_valid, sensor_fault} !== 14'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b want 0", {lv, pulses, f_code, f_valid, sensor_fault});
    end
    reset = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick(1);
      checks++;
      if (lv !== 7'h00 || pulses !== 3'b000) begin
        fails++;
        $display("FAIL reset_exit_edge%0d: levels=%b pulses=%b want 0/0", e, lv, pulses);
      end
    end
    tick(1);
    checks++;
    if (lv !== 7'h7f || pulses !== 3'b111) begin
      fails++;
      $display("FAIL reset_exit_edge6: levels=%b pulses=%b want 1111111/111", lv, pulses);
    end
    checks++;
    if (f_valid !== 1'b0 || f_code !== 2'b00) begin
      fails++;
      $display("FAIL all_floors_encode: f_code=%b f_valid=%b want 00/0", f_code, f_valid);
    end
    tick(1);
    checks++;
    if (pulses !== 3'b000 || lv !== 7'h7f) begin
      fails++;
      $display("FAIL reset_exit_edge7: levels=%b pulses=%b want 1111111/000", lv, pulses);
    end
    $display("test_reset: outputs rose on edge 6 after release");
  endtask

  task automatic test_press;
    set_raw(1'b0);
    do_reset();
    p2_raw = 1'b1;
    tick(5);
    checks++;
    if (p2 !== 1'b0) begin fails++; $display("FAIL press_edge5: p2=%b want 0", p2); end
    tick(1);
    checks++;
    if (p2 !== 1'b1 || pulses !== 3'b010) begin
      fails++;
      $display("FAIL press_edge6: p2=%b pulses=%b want 1/010", p2, pulses);
    end
    tick(1);
    checks++;
    if (p2 !== 1'b1 || pulses !== 3'b000) begin
      fails++;
      $display("FAIL press_edge7: p2=%b pulses=%b want 1/000", p2, pulses);
    end
    tick(3);
    p2_raw = 1'b0;
    tick(5);
    checks++;
    if (p2 !== 1'b1 || pulses !== 3'b000) begin
      fails++;
      $display("FAIL release_edge5: p2=%b pulses=%b want 1/000", p2, pulses);
    end
    tick(1);
    checks++;
    if (p2 !== 1'b0 || pulses !== 3'b000) begin
      fails++;
      $display("FAIL release_edge6: p2=%b pulses=%b want 0/000", p2, pulses);
    end
    $display("test_press: p2 press and release");
  endtask

  task automatic test_bounce;
    do_reset();
    for (int ph = 0; ph < 6; ph++) begin
      p1_raw = (ph % 2 == 0);
      for (int c = 0; c < 2; c++) begin
        tick(1);
        checks++;
        if (p1 !== 1'b0 || p1_pulse !== 1'b0) begin
          fails++;
          $display("FAIL bounce_ph%0d: p1=%b pulse=%b want 0/0", ph, p1, p1_pulse);
        end
      end
    end
    p1_raw = 1'b1;
    tick(5);
    checks++;
    if (p1 !== 1'b0) begin fails++; $display("FAIL bounce_settle_edge5: p1=%b want 0", p1); end
    tick(1);
    checks++;
    if (p1 !== 1'b1 || p1_pulse !== 1'b1) begin
      fails++;
      $display("FAIL bounce_settle_edge6: p1=%b pulse=%b want 1/1", p1, p1_pulse);
    end
    p1_raw = 1'b0;
    $display("test_bounce: p1 accepted 6 edges after last transition");
  endtask

  task automatic test_floor_glitch;
    set_raw(1'b0);
    do_reset();
    f3_raw = 1'b1;
    tick(6);
    checks++;
    if (f3 !== 1'b1 || f_code !== 2'b11 || f_valid !== 1'b1) begin
      fails++;
      $display("FAIL floor3_encode: f3=%b f_code=%b f_valid=%b want 1/11/1", f3, f_code, f_valid);
    end
    f1_raw = 1'b1;
    tick(3);
    f1_raw = 1'b0;
    for (int e = 0; e < 8; e++) begin
      tick(1);
      checks++;
      if (f1 !== 1'b0 || f_code !== 2'b11 || f_valid !== 1'b1) begin
        fails++;
        $display("FAIL f1_glitch_e%0d: f1=%b f_code=%b f_valid=%b want 0/11/1", e, f1, f_code, f_valid);
      end
    end
    $display("test_floor_glitch: 3-cycle f1 glitch rejected");
  endtask

  task automatic test_conflict;
    set_raw(1'b0);
    do_reset();
    f1_raw = 1'b1;
    f2_raw = 1'b1;
    tick(6);
    checks++;
    if (f1 !== 1'b1 || f2 !== 1'b1 || f_valid !== 1'b0 || f_code !== 2'b00 || sensor_fault !== 1'b0) begin
      fails++;
      $display("FAIL conflict_encode: f1=%b f2=%b f_code=%b f_valid=%b fault=%b want 1/1/00/0/0",
               f1, f2, f_code, f_valid, sensor_fault);
    end
    tick(7);
    checks++;
    if (sensor_fault !== 1'b0) begin fails++; $display("FAIL conflict_7cyc: fault=%b want 0", sensor_fault); end
    tick(1);
    checks++;
    if (sensor_fault !== 1'b1) begin fails++; $display("FAIL conflict_8cyc: fault=%b want 1", sensor_fault); end
    f1_raw = 1'b0;
    f2_raw = 1'b0;
    tick(10);
    checks++;
    if (sensor_fault !== 1'b1 || f1 !== 1'b0 || f2 !== 1'b0) begin
      fails++;
      $display("FAIL fault_sticky: fault=%b f1=%b f2=%b want 1/0/0", sensor_fault, f1, f2);
    end
    do_reset();
    checks++;
    if (sensor_fault !== 1'b0) begin fails++; $display("FAIL fault_reset: fault=%b want 0", sensor_fault); end
    $display("test_conflict: fault set after 8 conflict cycles, cleared by reset");
  endtask

  task automatic test_mid_reset;
    set_raw(1'b0);
    do_reset();
    p3_raw = 1'b1;
    tick(4);
    reset = 1'b1;
    #1;
    checks++;
    if (p3 !== 1'b0) begin fails++; $display("FAIL mid_reset_assert: p3=%b want 0", p3); end
    tick(1);
    reset = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick(1);
      checks++;
      if (p3 !== 1'b0) begin fails++; $display("FAIL mid_reset_edge%0d: p3=%b want 0", e, p3); end
    end
    tick(1);
    checks++;
    if (p3 !== 1'b1 || p3_pulse !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset_edge6: p3=%b pulse=%b want 1/1", p3, p3_pulse);
    end
    $display("test_mid_reset: count discarded, full window after release");
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_floor_glitch();
    test_conflict();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
